hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MD_LATENCY, default 8, mult/div busy cycles after accept; legal range 2..255.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 rs_ID, rt_ID  input  5 each  source registers of the instruction in ID.
REQ-005 rs_EX, rt_EX  input  5 each  source registers of the instruction in EX.
REQ-006 rd_EX  input  5  destination register of EX; reg_write_EX, mem_read_EX  input  1  its write enable and load flag.
REQ-007 rd_MEM  input  5, reg_write_MEM  input  1  destination and write enable in MEM.
REQ-008 rd_WB  input  5, reg_write_WB  input  1  destination and write enable in WB.
REQ-009 branch_taken_EX  input  1  taken branch or jump resolved in EX.
REQ-010 md_start_ID  input  1  ID holds a mult/div; md_read_ID  input  1  ID holds mfhi/mflo.
REQ-011 stall_pc, stall_id  output  1 each  hold PC and the IF/ID register.
REQ-012 flush_id, flush_ex  output  1 each  zero the IF/ID and ID/EX registers (bubble).
REQ-013 fwd_a, fwd_b  output  2 each  EX operand select: 00 register file, 10 MEM result, 01 WB result.
REQ-014 md_busy  output  1  registered; mult/div unit occupied.
REQ-015 stall_count  output  16  registered; number of cycles with stall_pc=1.

Function
REQ-016 Load-use hazard: mem_read_EX=1, rd_EX!=0 and rd_EX equals rs_ID or rt_ID -> stall_pc=1, stall_id=1, flush_ex=1 in the same cycle.
REQ-017 MD hazard: md_busy=1 and (md_read_ID=1 or md_start_ID=1) -> stall_pc=1, stall_id=1, flush_ex=1.
REQ-018 branch_taken_EX=1 -> flush_id=1, flush_ex=1, stall_pc=0, stall_id=0, overriding REQ-016/REQ-017.
REQ-019 No hazard and no branch -> stall_pc, stall_id, flush_id, flush_ex all 0.
REQ-020 fwd_a=10 when reg_write_MEM=1, rd_MEM!=0, rd_MEM==rs_EX; else 01 when reg_write_WB=1, rd_WB!=0, rd_WB==rs_EX; else 00; MEM wins over WB.
REQ-021 fwd_b follows REQ-020 with rt_EX in place of rs_EX.
REQ-022 Stall, flush and forward outputs are combinational from inputs and md_busy; no added latency.
REQ-023 MD FSM states IDLE and BUSY with an 8-bit down-counter.
REQ-024 IDLE -> BUSY when md_start_ID=1 and branch_taken_EX=0 and no load-use stall that cycle (accept); counter loads MD_LATENCY-1.
REQ-025 BUSY: counter decrements each cycle; at counter=0 next state IDLE; md_busy=1 exactly in BUSY, i.e. MD_LATENCY cycles starting the cycle after accept.
REQ-026 md_start_ID during BUSY is not accepted (stalled per REQ-017); it is accepted in the first IDLE cycle.
REQ-027 branch_taken_EX during BUSY does not abort the operation.
REQ-028 stall_count increments on each edge where stall_pc=1; saturates at 16'hFFFF.

Reset
REQ-029 reset=1 immediately forces state IDLE, counter 0, md_busy=0, stall_count=0, independent of clk.
REQ-030 Reset during BUSY abandons the operation; first cycle after release is IDLE.
REQ-031 Combinational outputs follow inputs during reset, with md_busy treated as 0.

Verification
REQ-032 mem_read_EX=1, rd_EX=5, rs_ID=5 -> stall_pc=stall_id=flush_ex=1, flush_id=0; stall_count 0->1 after the edge.
REQ-033 Same as REQ-032 with rd_EX=0 -> all stall/flush outputs 0.
REQ-034 rs_EX=rt_EX=7, reg_write_MEM=1, rd_MEM=7, reg_write_WB=1, rd_WB=7 -> fwd_a=fwd_b=10; drop reg_write_MEM -> 01.
REQ-035 Accept md_start_ID at edge N with MD_LATENCY=8 -> md_busy=1 for edges N+1..N+8; md_read_ID=1 during that window stalls; stall released in cycle N+9.
REQ-036 Load-use hazard plus branch_taken_EX=1 same cycle -> flush_id=flush_ex=1, stall_pc=0, stall_count unchanged.
REQ-037 Assert reset asynchronously mid-BUSY -> md_busy=0 and stall_count=0 before the next edge; force 65536 stall cycles -> stall_count holds 16'hFFFF.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard control for a five-stage pipeline: load-use and mult/div stall
// detection, taken-branch flushing, EX operand forwarding, a mult/div
// busy tracker and a saturating stall-cycle counter.
module hazard_ctrl #(
  parameter int MD_LATENCY = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_ID,
  input  logic [4:0] rt_ID,
  input  logic [4:0] rs_EX,
  input  logic [4:0] rt_EX,
  input  logic [4:0] rd_EX,
  input  logic       reg_write_EX,
  input  logic       mem_read_EX,
  input  logic [4:0] rd_MEM,
  input  logic       reg_write_MEM,
  input  logic [4:0] rd_WB,
  input  logic       reg_write_WB,
  input  logic       branch_taken_EX,
  input  logic       md_start_ID,
  input  logic       md_read_ID,
  output logic       stall_pc,
  output logic       stall_id,
  output logic       flush_id,
  output logic       flush_ex,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       md_busy,
  output logic [15:0] stall_count
);

  typedef enum logic {IDLE, BUSY} md_state_e;

  localparam logic [7:0] MD_LOAD = 8'(MD_LATENCY - 1);

  md_state_e   state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] stall_count_q, stall_count_d;
  logic        load_use;
  logic        md_hazard;
  logic        md_accept;

  // The EX write enable is implied by mem_read_EX for loads, so it is not
  // needed by any of the hazard equations.
  logic unused_in;
  assign unused_in = reg_write_EX;

  // MEM result is newer than WB, so it takes priority; r0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic [4:0] rd_m, input logic rw_m,
                                         input logic [4:0] rd_w, input logic rw_w);
    if (rw_m && (rd_m != 5'd0) && (rd_m == src))      return 2'b10;
    else if (rw_w && (rd_w != 5'd0) && (rd_w == src)) return 2'b01;
    else                                              return 2'b00;
  endfunction

  assign md_busy     = (state_q == BUSY);
  assign stall_count = stall_count_q;

  // Hazard detection, branch flush priority and forwarding selects.
  always_comb begin
    stall_pc  = 1'b0;
    stall_id  = 1'b0;
    flush_id  = 1'b0;
    flush_ex  = 1'b0;
    load_use  = mem_read_EX && (rd_EX != 5'd0) &&
                ((rd_EX == rs_ID) || (rd_EX == rt_ID));
    md_hazard = md_busy && (md_read_ID || md_start_ID);
    if (branch_taken_EX) begin
      flush_id = 1'b1;
      flush_ex = 1'b1;
    end else if (load_use || md_hazard) begin
      stall_pc = 1'b1;
      stall_id = 1'b1;
      flush_ex = 1'b1;
    end
    fwd_a = fwd_sel(rs_EX, rd_MEM, reg_write_MEM, rd_WB, reg_write_WB);
    fwd_b = fwd_sel(rt_EX, rd_MEM, reg_write_MEM, rd_WB, reg_write_WB);
  end

  // Mult/div occupancy FSM and saturating stall counter next-state.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    stall_count_d = stall_count_q;
    md_accept     = (state_q == IDLE) && md_start_ID && !branch_taken_EX && !load_use;
    case (state_q)
      IDLE: begin
        if (md_accept) begin
          state_d = BUSY;
          cnt_d   = MD_LOAD;
        end
      end
      BUSY: begin
        if (cnt_q == 8'd0) state_d = IDLE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      default: state_d = IDLE;
    endcase
    if (stall_pc && (stall_count_q != 16'hFFFF))
      stall_count_d = stall_count_q + 16'd1;
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= 8'd0;
      stall_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

endmodule
